// File: rtl/uart_rx_os.sv
// 16x-oversampled UART receiver with majority-vote sampling, parity/framing/overrun
// detection and a valid/ready output. Optional break detection: UART_RX_BREAK_DET_EN.
`timescale 1ns/1ps
module uart_rx_os #(
  parameter int Clk_Freq   = 50_000_000,
  parameter int Baud_Rate  = 115200,
  parameter int DATA_LEN   = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                clk_sys,
  input  logic                rst,
  input  logic                uart_rx,
  output logic [DATA_LEN-1:0] rx_dat,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                parity_err,
  output logic                frame_err,
  output logic                overrun_err,
  output logic                busy,
  output logic                break_det
);

  localparam int DIV   = Clk_Freq / (Baud_Rate * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TCK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_LEN);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [TCK_W-1:0] T_S0     = TCK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TCK_W-1:0] T_S1     = TCK_W'(OVERSAMPLE / 2);
  localparam logic [TCK_W-1:0] T_S2     = TCK_W'(OVERSAMPLE / 2 + 1);
  localparam logic [TCK_W-1:0] T_LAST   = TCK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] B_LAST   = BIT_W'(DATA_LEN - 1);

`ifdef UART_RX_BREAK_DET_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`endif

  state_t state, state_nx;

  logic                rx_meta, rx_s, rx_prev;
  logic [DIV_W-1:0]    div_cnt;
  logic [TCK_W-1:0]    tick_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic                stop_cnt;
  logic [1:0]          smp;
  logic [DATA_LEN-1:0] data_sr;
  logic                par_bit;
  logic                ferr_acc;
  logic                done;

  logic tick, fall, start_edge, mid_done, bit_end, maj, last_stop;
  logic par_exp, perr;

  // Two-flop synchronizer plus one history flop for edge detection; idle line is 1.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      // NOTE: registered state always uses <= so every flop samples pre-edge values.
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall       = rx_prev & ~rx_s;
  assign start_edge = (state == S_IDLE) && fall;
  assign tick       = (div_cnt == DIV_LAST);
  assign mid_done   = tick && (tick_cnt == T_S2);
  assign bit_end    = tick && (tick_cnt == T_LAST);
  assign maj        = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
  assign last_stop  = (stop_cnt == 1'(STOP_BITS - 1));
  assign par_exp    = (PARITY == 1) ? ~^data_sr : ^data_sr;
  assign perr       = (PARITY != 0) && (par_bit != par_exp);
  assign busy       = (state != S_IDLE);

`ifdef UART_RX_BREAK_DET_EN
  logic stop_one, done_brk, brk_now;
  assign brk_now = (data_sr == '0) && ((PARITY == 0) || !par_bit) && !stop_one && !maj;
`else
  assign break_det = 1'b0;
`endif

  // Tick divider, re-phased on every start edge so the sample points track the frame.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst)                  div_cnt <= '0;
    else if (start_edge || tick) div_cnt <= '0;
    else                      div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    // NOTE: default first, so no path through the case can leave state_nx unassigned (latch).
    state_nx = state;
    case (state)
      S_IDLE:   if (fall) state_nx = S_START;
      S_START: begin
        if (mid_done && maj) state_nx = S_IDLE;
        else if (bit_end)    state_nx = S_DATA;
      end
      S_DATA:   if (bit_end && bit_cnt == B_LAST) state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_nx = S_STOP;
      S_STOP: begin
        if (mid_done && last_stop) begin
`ifdef UART_RX_BREAK_DET_EN
          state_nx = brk_now ? S_BRK_WAIT : S_IDLE;
`else
          state_nx = S_IDLE;
`endif
        end
      end
`ifdef UART_RX_BREAK_DET_EN
      S_BRK_WAIT: if (tick && rx_s && tick_cnt == T_LAST) state_nx = S_IDLE;
`endif
      default:  state_nx = S_IDLE;
    endcase
  end

  // Bit-level datapath: tick phase, samples, shift register and frame flags.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      smp      <= 2'b11;
      data_sr  <= '0;
      par_bit  <= 1'b0;
      ferr_acc <= 1'b0;
      done     <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      stop_one <= 1'b0;
      done_brk <= 1'b0;
`endif
    end else begin
      done <= 1'b0;

      if (start_edge) tick_cnt <= '0;
`ifdef UART_RX_BREAK_DET_EN
      // Break recovery needs an unbroken run of high ticks; any low restarts it.
      else if (state_nx == S_BRK_WAIT && (state != S_BRK_WAIT || !rx_s)) tick_cnt <= '0;
`endif
      else if (tick) tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + 1'b1;

      if (tick && tick_cnt == T_S0) smp[0] <= rx_s;
      if (tick && tick_cnt == T_S1) smp[1] <= rx_s;

      if (start_edge) begin
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
        par_bit  <= 1'b0;
        ferr_acc <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        stop_one <= 1'b0;
`endif
      end

      if (state == S_DATA && mid_done) data_sr <= {maj, data_sr[DATA_LEN-1:1]};
      if (state == S_DATA && bit_end && bit_cnt != B_LAST) bit_cnt <= bit_cnt + 1'b1;
      if (state == S_PARITY && mid_done) par_bit <= maj;

      if (state == S_STOP && mid_done) begin
        ferr_acc <= ferr_acc | ~maj;
`ifdef UART_RX_BREAK_DET_EN
        stop_one <= stop_one | maj;
`endif
        if (last_stop) begin
          done <= 1'b1;
`ifdef UART_RX_BREAK_DET_EN
          done_brk <= brk_now;
`endif
        end
      end
      if (state == S_STOP && bit_end) stop_cnt <= stop_cnt + 1'b1;
    end
  end

  // Output holding register and handshake; a completion wins over a plain consume.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      rx_dat      <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      break_det   <= 1'b0;
`endif
    end else begin
      overrun_err <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      break_det   <= 1'b0;
`endif
      if (done) begin
`ifdef UART_RX_BREAK_DET_EN
        if (done_brk) break_det <= 1'b1;
        else
`endif
        if (!rx_valid || rx_ready) begin
          rx_dat     <= data_sr;
          parity_err <= perr;
          frame_err  <= ferr_acc;
          rx_valid   <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: one default 8N1 instance and one 8E1 instance.
// Break cases follow UART_RX_BREAK_DET_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_uart_rx_os;

  localparam int BIT_NS = 8680;

  logic       clk_sys = 1'b0;
  logic       rst = 1'b1;
  logic       rx_a = 1'b1, rx_b = 1'b1;
  logic       ready_a = 1'b1, ready_b = 1'b1;
  logic [7:0] dat_a, dat_b;
  logic       valid_a, valid_b, perr_a, perr_b, ferr_a, ferr_b;
  logic       ovr_a, ovr_b, busy_a, busy_b, brk_a, brk_b;

  int checks = 0;
  int failures = 0;

  uart_rx_os dut_a (
    .clk_sys(clk_sys), .rst(rst), .uart_rx(rx_a), .rx_dat(dat_a), .rx_valid(valid_a),
    .rx_ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun_err(ovr_a),
    .busy(busy_a), .break_det(brk_a)
  );

  uart_rx_os #(.PARITY(2)) dut_b (
    .clk_sys(clk_sys), .rst(rst), .uart_rx(rx_b), .rx_dat(dat_b), .rx_valid(valid_b),
    .rx_ready(ready_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun_err(ovr_b),
    .busy(busy_b), .break_det(brk_b)
  );

  always #10 clk_sys = ~clk_sys;

  // Event monitors: count rising edges of rx_valid and pulse outputs, capture delivered words.
  int         a_nvalid = 0, a_novr = 0, a_nbrk = 0, a_len = 0, a_last_len = 0;
  logic [7:0] a_dat = 8'h00;
  logic       a_perr = 1'b0, a_ferr = 1'b0, a_prev = 1'b0;
  int         b_nvalid = 0;
  logic [7:0] b_dat = 8'h00;
  logic       b_perr = 1'b0, b_prev = 1'b0;

  always @(negedge clk_sys) begin
    if (valid_a && !a_prev) begin
      a_nvalid++; a_dat = dat_a; a_perr = perr_a; a_ferr = ferr_a; a_len = 0;
    end
    if (valid_a) a_len++;
    else if (a_prev) a_last_len = a_len;
    if (ovr_a) a_novr++;
    if (brk_a) a_nbrk++;
    a_prev = valid_a;
    if (valid_b && !b_prev) begin
      b_nvalid++; b_dat = dat_b; b_perr = perr_b;
    end
    b_prev = valid_b;
  end

  task automatic drive_bit(input int line, input logic v);
    if (line == 0) rx_a = v; else rx_b = v;
    #(BIT_NS);
  endtask

  task automatic send_frame(input int line, input logic [7:0] d, input bit has_par,
                            input logic par, input logic stop);
    drive_bit(line, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(line, d[i]);
    if (has_par) drive_bit(line, par);
    drive_bit(line, stop);
    if (line == 0) rx_a = 1'b1; else rx_b = 1'b1;
    repeat (4) @(negedge clk_sys);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (5) @(negedge clk_sys);
    checks++; if ({valid_a, perr_a, ferr_a, ovr_a, busy_a, brk_a} !== 6'b0) begin
      failures++; $display("FAIL reset_flags_a: got %b expected 000000", {valid_a, perr_a, ferr_a, ovr_a, busy_a, brk_a});
    end
    checks++; if (dat_a !== 8'h00) begin
      failures++; $display("FAIL reset_dat_a: got %h expected 00", dat_a);
    end
    checks++; if ({valid_b, perr_b, ferr_b, ovr_b, busy_b, brk_b, dat_b} !== 14'b0) begin
      failures++; $display("FAIL reset_b: got %b expected all 0", {valid_b, perr_b, ferr_b, ovr_b, busy_b, brk_b, dat_b});
    end
    rst = 1'b0;
    repeat (5) @(negedge clk_sys);
    checks++; if (busy_a !== 1'b0) begin
      failures++; $display("FAIL reset_release_busy: got %b expected 0", busy_a);
    end
  endtask

  task automatic test_basic;
    int n0 = a_nvalid;
    ready_a = 1'b1;
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
    checks++; if (a_nvalid - n0 !== 1) begin
      failures++; $display("FAIL basic_count: got %0d expected 1", a_nvalid - n0);
    end
    checks++; if (a_dat !== 8'h55) begin
      failures++; $display("FAIL basic_dat: got %h expected 55", a_dat);
    end
    checks++; if ({a_perr, a_ferr} !== 2'b00) begin
      failures++; $display("FAIL basic_flags: got %b expected 00", {a_perr, a_ferr});
    end
    checks++; if (a_last_len !== 1) begin
      failures++; $display("FAIL basic_valid_len: got %0d expected 1", a_last_len);
    end
    checks++; if ({valid_a, busy_a} !== 2'b00) begin
      failures++; $display("FAIL basic_idle: got %b expected 00", {valid_a, busy_a});
    end
  endtask

  task automatic test_glitch;
    int  n0 = a_nvalid;
    bit  saw_busy = 0;
    bit  back_idle = 0;
    @(negedge clk_sys);
    rx_a = 1'b0;
    #120;
    rx_a = 1'b1;
    for (int i = 0; i < BIT_NS / 20; i++) begin
      @(negedge clk_sys);
      if (busy_a) saw_busy = 1;
      else if (saw_busy) begin back_idle = 1; break; end
    end
    checks++; if (!(saw_busy && back_idle)) begin
      failures++; $display("FAIL glitch_busy: got saw=%0d idle=%0d expected 1 1", saw_busy, back_idle);
    end
    #(BIT_NS);
    checks++; if (a_nvalid - n0 !== 0) begin
      failures++; $display("FAIL glitch_novalid: got %0d expected 0", a_nvalid - n0);
    end
  endtask

  task automatic test_parity;
    int n0 = b_nvalid;
    send_frame(1, 8'hA5, 1'b1, 1'b1, 1'b1);
    checks++; if ({b_dat, b_perr} !== {8'hA5, 1'b1}) begin
      failures++; $display("FAIL parity_bad: got %h/%b expected a5/1", b_dat, b_perr);
    end
    send_frame(1, 8'hA5, 1'b1, 1'b0, 1'b1);
    checks++; if ({b_dat, b_perr} !== {8'hA5, 1'b0}) begin
      failures++; $display("FAIL parity_good: got %h/%b expected a5/0", b_dat, b_perr);
    end
    checks++; if (b_nvalid - n0 !== 2) begin
      failures++; $display("FAIL parity_count: got %0d expected 2", b_nvalid - n0);
    end
  endtask

  task automatic test_frame_err;
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    checks++; if ({a_dat, a_ferr, a_perr} !== {8'h3C, 1'b1, 1'b0}) begin
      failures++; $display("FAIL frame_err: got %h/%b/%b expected 3c/1/0", a_dat, a_ferr, a_perr);
    end
    #(BIT_NS);
  endtask

  task automatic test_break;
    int n0 = a_nvalid;
    int b0 = a_nbrk;
    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b0);
    #(2 * BIT_NS);
`ifdef UART_RX_BREAK_DET_EN
    checks++; if (a_nbrk - b0 !== 1) begin
      failures++; $display("FAIL break_pulse: got %0d expected 1", a_nbrk - b0);
    end
    checks++; if (a_nvalid - n0 !== 0) begin
      failures++; $display("FAIL break_novalid: got %0d expected 0", a_nvalid - n0);
    end
`else
    checks++; if (a_nbrk - b0 !== 0) begin
      failures++; $display("FAIL break_tied: got %0d expected 0", a_nbrk - b0);
    end
    checks++; if ({a_nvalid - n0 == 1, a_dat, a_ferr} !== {1'b1, 8'h00, 1'b1}) begin
      failures++; $display("FAIL break_word: got n=%0d %h/%b expected n=1 00/1", a_nvalid - n0, a_dat, a_ferr);
    end
`endif
    checks++; if (busy_a !== 1'b0) begin
      failures++; $display("FAIL break_idle: got %b expected 0", busy_a);
    end
  endtask

  task automatic test_back_to_back;
    int n0 = a_nvalid;
    int o0 = a_novr;
    @(negedge clk_sys);
    ready_a = 1'b0;
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
    checks++; if ({valid_a, dat_a} !== {1'b1, 8'h11}) begin
      failures++; $display("FAIL b2b_held: got %b/%h expected 1/11", valid_a, dat_a);
    end
    checks++; if (a_novr - o0 !== 1) begin
      failures++; $display("FAIL b2b_overrun: got %0d expected 1", a_novr - o0);
    end
    checks++; if (a_nvalid - n0 !== 1) begin
      failures++; $display("FAIL b2b_count: got %0d expected 1", a_nvalid - n0);
    end
    ready_a = 1'b1;
    @(negedge clk_sys);
    checks++; if (valid_a !== 1'b0) begin
      failures++; $display("FAIL b2b_consume: got %b expected 0", valid_a);
    end
  endtask

  task automatic test_reset_mid;
    int n0;
    ready_a = 1'b0;
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    checks++; if ({valid_a, dat_a} !== {1'b1, 8'h5A}) begin
      failures++; $display("FAIL rmid_pre: got %b/%h expected 1/5a", valid_a, dat_a);
    end
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
    rx_a = 1'b0;
    #(BIT_NS / 2);
    rst = 1'b1;
    #1;
    checks++; if ({valid_a, busy_a, perr_a, ferr_a, ovr_a, dat_a} !== 13'b0) begin
      failures++; $display("FAIL rmid_outputs: got %b/%b/%h expected 0/0/00", valid_a, busy_a, dat_a);
    end
    #(BIT_NS / 2 - 1);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    @(negedge clk_sys);
    rst = 1'b0;
    ready_a = 1'b1;
    #(2 * BIT_NS);
    n0 = a_nvalid;
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
    checks++; if ({a_nvalid - n0 == 1, a_dat, a_perr, a_ferr} !== {1'b1, 8'h81, 2'b00}) begin
      failures++; $display("FAIL rmid_next: got n=%0d %h/%b%b expected n=1 81/00", a_nvalid - n0, a_dat, a_perr, a_ferr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_parity();
    test_frame_err();
    test_break();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
